sram_8blk_seq: RTL
==================

// Module: sram_8blk_seq
// PURPOSE
//  Sequencer/arbiter for the 8-block coefficient SRAM (sram_8blk: 8 x 256 x 20b, active-low CEN/WEN).
//  It streams a full 2048-word load into the blocks in CADDR order, then serves tap-read requests from the FIR datapath.
//  It drives all eight block read addresses per request and flags when Q7..Q0 are valid.
//  It owns every SRAM control pin, so no other block drives CEN/WEN/CADDR/D/A*.
// PARAMETERS
//  DW          20   data word width (D, Q*)
//  AW          8    per-block address width (256 words/block)
//  NBLK        8    number of blocks; CADDR width = AW+log2(NBLK) = 11
//  ADDR_STRIDE 0    per-block read address offset: A_k = rd_base + k*ADDR_STRIDE, mod 2^AW
// PORTS
//  clk         in   1        system clock, all state on posedge
//  rst         in   1        asynchronous active-high reset
//  ld_valid    in   1        load word present
//  ld_ready    out  1        load word accepted when ld_valid&ld_ready (= state LOAD)
//  ld_data     in   DW       load word
//  reload      in   1        pulse: discard contents, restart load at CADDR 0
//  loaded      out  1        1 while in RUN (all 2048 words written)
//  rd_req      in   1        tap-read request
//  rd_ack      out  1        request accepted this cycle (combinational)
//  rd_base     in   AW       base address sampled on rd_ack
//  rd_qvalid   out  1        SRAM Q7..Q0 hold the acked read's data this cycle
//  sram_cen_n  out  1        SRAM chip enable, active low
//  sram_wen_n  out  1        SRAM write enable, active low
//  sram_caddr  out  11       write address {blk[2:0], addr[7:0]}
//  sram_d      out  DW       write data
//  sram_a      out  NBLK*AW  read addresses, block k at [k*AW +: AW]
// BEHAVIOUR
//  - States: LOAD -> RUN on acceptance of word 2047; RUN -> LOAD on reload if no read in flight; RUN -> DRAIN on reload with read in flight; DRAIN -> LOAD once rd_qvalid has fired.
//  - Reset: state LOAD, wr_ptr 0, sram_cen_n=1, sram_wen_n=1, sram_caddr=0, sram_d=0, sram_a=0, rd_qvalid=0, loaded=0; ld_ready=1.
//  - All sram_* outputs are registered. Idle cycles: cen_n=1, wen_n=1, caddr/d/a hold their last value.
//  - Load: accept in cycle c -> cycle c+1 has cen_n=0, wen_n=0, caddr=wr_ptr, d=ld_data; wr_ptr+1.
//  - Load, no accept (ld_valid=0): cen_n=1 and wr_ptr holds. Words land in order with no gaps in addressing.
//  - wr_ptr wraps 2047->0 on entry to RUN. ld_ready=0 outside LOAD, so extra load words are not accepted.
//  - Read: rd_ack = rd_req & (state==RUN) & ~reload [& gap rule]. rd_ack is never asserted in LOAD or DRAIN.
//  - Read ack in cycle c -> cycle c+1 has cen_n=0, wen_n=1, sram_a[k] = (rd_base + k*ADDR_STRIDE) mod 256; cycle c+2 has rd_qvalid=1 for one cycle. Latency is 2.
//  - Read pipelining: reads may be acked back-to-back; each ack yields exactly one rd_qvalid, in order.
//  - reload in LOAD: wr_ptr=0 next cycle. Any word accepted in the same cycle is dropped (no write issued).
//  - reload and rd_req in the same cycle: reload wins, no ack.
//  - reload with a read in flight: that read completes (its rd_qvalid still fires), then LOAD.
//  - rst mid-operation: immediate return to reset values; any in-flight rd_qvalid is cancelled.
// CONFIGURATION
//  SRAM_RD_GAP_EN defined: a mandatory idle cycle (cen_n=1) follows each read.
//    rd_ack is forced 0 in the cycle after an ack, so reads issue at most every other cycle.
//  SRAM_RD_GAP_EN undefined: back-to-back reads at one per cycle. Loads are unaffected in both cases.
// TESTING
//  1. Reset, then ld_valid=1 for 2048 cycles with ld_data=i -> caddr 0..2047 in order, cen_n=wen_n=0 each cycle; ld_ready falls and loaded=1 after word 2047.
//  2. ld_valid toggling 1,0,1 -> cen_n 0,1,0; caddr advances by 1 only on accepted words.
//  3. After load, ADDR_STRIDE=1, rd_base=255 -> sram_a = 255,0,1,..,6 for blocks 0..7; rd_qvalid 2 cycles after ack; Q_k equals the stored word.
//  4. rd_req held 4 cycles -> 4 consecutive acks and 4 rd_qvalid pulses; with SRAM_RD_GAP_EN, acks on cycles 0,2 only and cen_n toggles.
//  5. reload in the cycle after a read ack -> rd_qvalid still fires, then ld_ready=1 and the next write is at caddr 0; rd_req before the load completes -> rd_ack=0.
//  6. rst asserted at wr_ptr=100 -> cen_n=1 and wen_n=1 immediately; after release the load restarts at caddr 0.

Source files
------------

// File: rtl/sram_8blk_seq.sv
// Load/read sequencer for the 8-block coefficient SRAM; owns every SRAM pin.
// Define SRAM_RD_GAP_EN to force an idle cycle after every read.
module sram_8blk_seq #(
   parameter int DW          = 20,
   parameter int AW          = 8,
   parameter int NBLK        = 8,
   parameter int ADDR_STRIDE = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ld_valid,
   output logic                        ld_ready,
   input  logic [DW-1:0]               ld_data,
   input  logic                        reload,
   output logic                        loaded,
   input  logic                        rd_req,
   output logic                        rd_ack,
   input  logic [AW-1:0]               rd_base,
   output logic                        rd_qvalid,
   output logic                        sram_cen_n,
   output logic                        sram_wen_n,
   output logic [AW+$clog2(NBLK)-1:0]  sram_caddr,
   output logic [DW-1:0]               sram_d,
   output logic [NBLK*AW-1:0]          sram_a
);

   localparam int CW = AW + $clog2(NBLK);

   typedef enum logic [1:0] {
      S_LOAD,
      S_RUN,
      S_DRAIN
   } state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      wr_ptr_q, wr_ptr_d;
   logic               rd_issue_q, rd_issue_d;
   logic               rd_qvalid_q, rd_qvalid_d;
   logic               cen_n_q, cen_n_d;
   logic               wen_n_q, wen_n_d;
   logic [CW-1:0]      caddr_q, caddr_d;
   logic [DW-1:0]      d_q, d_d;
   logic [NBLK*AW-1:0] a_q, a_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_LOAD;
         wr_ptr_q    <= '0;
         rd_issue_q  <= 1'b0;
         rd_qvalid_q <= 1'b0;
         cen_n_q     <= 1'b1;
         wen_n_q     <= 1'b1;
         caddr_q     <= '0;
         d_q         <= '0;
         a_q         <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_issue_q  <= rd_issue_d;
         rd_qvalid_q <= rd_qvalid_d;
         cen_n_q     <= cen_n_d;
         wen_n_q     <= wen_n_d;
         caddr_q     <= caddr_d;
         d_q         <= d_d;
         a_q         <= a_d;
      end
   end

   // rd_issue_q marks a read on the SRAM pins this cycle
`ifdef SRAM_RD_GAP_EN
   assign rd_ack = rd_req & (state_q == S_RUN) & ~reload & ~rd_issue_q;
`else
   assign rd_ack = rd_req & (state_q == S_RUN) & ~reload;
`endif

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_issue_d  = 1'b0;
      rd_qvalid_d = rd_issue_q;
      cen_n_d     = 1'b1;
      wen_n_d     = 1'b1;
      caddr_d     = caddr_q;
      d_d         = d_q;
      a_d         = a_q;
      unique case (state_q)
         S_LOAD: begin
            if (reload) begin
               wr_ptr_d = '0;
            end else if (ld_valid) begin
               cen_n_d  = 1'b0;
               wen_n_d  = 1'b0;
               caddr_d  = wr_ptr_q;
               d_d      = ld_data;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (wr_ptr_q == '1) state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (reload) begin
               wr_ptr_d = '0;
               state_d  = rd_issue_q ? S_DRAIN : S_LOAD;
            end else if (rd_ack) begin
               cen_n_d    = 1'b0;
               rd_issue_d = 1'b1;
               for (int k = 0; k < NBLK; k++) begin
                  a_d[k*AW +: AW] = rd_base + AW'(k * ADDR_STRIDE);
               end
            end
         end
         S_DRAIN: begin
            if (rd_qvalid_q) state_d = S_LOAD;
         end
         default: state_d = S_LOAD;
      endcase
   end

   assign ld_ready   = (state_q == S_LOAD);
   assign loaded     = (state_q == S_RUN);
   assign rd_qvalid  = rd_qvalid_q;
   assign sram_cen_n = cen_n_q;
   assign sram_wen_n = wen_n_q;
   assign sram_caddr = caddr_q;
   assign sram_d     = d_q;
   assign sram_a     = a_q;

endmodule
